vr_pipe_n: RTL

VR_PIPE_N -- requirements
Module: vr_pipe_n

---
 rtl/vr_pipe_n_pkg.sv | 15 +
 rtl/vr_stage.sv | 88 ++++++++
 rtl/vr_pipe_n.sv | 73 +++++++
 3 files changed

// File: rtl/vr_pipe_n_pkg.sv
// Shared types and helpers for the valid/ready pipeline slice.
// Holds the stage-mode selector and the occupancy counter width.
package vr_pipe_n_pkg;

    typedef enum logic {
        VR_PIPE = 1'b0,
        VR_SKID = 1'b1
    } vr_mode_e;

    // Wide enough to count 0..2*DEPTH, the largest capacity over both modes.
    function automatic int occ_w(input int depth);
        return $clog2(2 * depth + 1);
    endfunction

endpackage

// File: rtl/vr_stage.sv
// One valid/ready register stage: single-entry with combinational ready (VR_PIPE)
// or main+skid entry with registered ready (VR_SKID).
module vr_stage
    import vr_pipe_n_pkg::*;
#(
    parameter int       W    = 8,
    parameter vr_mode_e MODE = VR_PIPE
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_vld,
    input  logic [W-1:0] in_data,
    output logic         in_rdy,
    output logic         out_vld,
    output logic [W-1:0] out_data,
    input  logic         out_rdy
);

    generate
        if (MODE == VR_PIPE) begin : g_pipe
            logic         r_vld;
            logic [W-1:0] r_data;

            assign in_rdy   = out_rdy | ~r_vld;
            assign out_vld  = r_vld;
            assign out_data = r_data;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_vld  <= 1'b0;
                    r_data <= '0;
                end else if (flush) begin
                    r_vld <= 1'b0;
                end else if (in_vld && in_rdy) begin
                    r_vld  <= 1'b1;
                    r_data <= in_data;
                end else if (out_rdy) begin
                    r_vld <= 1'b0;
                end
            end
        end else begin : g_skid
            logic         r_main_vld;
            logic [W-1:0] r_main_data;
            logic         r_skid_vld;
            logic [W-1:0] r_skid_data;
            logic         w_pop;
            logic         w_take;

            // Ready comes only from the skid flag, so upstream never sees out_rdy.
            assign in_rdy   = ~r_skid_vld;
            assign out_vld  = r_main_vld;
            assign out_data = r_main_data;
            assign w_pop    = r_main_vld & out_rdy;
            assign w_take   = in_vld & ~r_skid_vld;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_main_vld  <= 1'b0;
                    r_main_data <= '0;
                    r_skid_vld  <= 1'b0;
                    r_skid_data <= '0;
                end else if (flush) begin
                    r_main_vld <= 1'b0;
                    r_skid_vld <= 1'b0;
                end else if (w_pop) begin
                    if (r_skid_vld) begin
                        r_main_data <= r_skid_data;
                        r_skid_vld  <= 1'b0;
                    end else if (w_take) begin
                        r_main_data <= in_data;
                    end else begin
                        r_main_vld <= 1'b0;
                    end
                end else if (w_take) begin
                    if (r_main_vld) begin
                        r_skid_vld  <= 1'b1;
                        r_skid_data <= in_data;
                    end else begin
                        r_main_vld  <= 1'b1;
                        r_main_data <= in_data;
                    end
                end
            end
        end
    endgenerate

endmodule

// File: rtl/vr_pipe_n.sv
// DEPTH cascaded valid/ready stages with a flush input and an occupancy counter.
// Flush masks both handshakes at the boundary so nothing enters or leaves on that edge.
module vr_pipe_n
    import vr_pipe_n_pkg::*;
#(
    parameter int       W     = 8,
    parameter int       DEPTH = 2,
    parameter vr_mode_e MODE  = VR_PIPE
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_vld,
    input  logic [W-1:0]               s_data,
    output logic                       s_rdy,
    output logic                       m_vld,
    output logic [W-1:0]               m_data,
    input  logic                       m_rdy,
    input  logic                       flush,
    output logic [occ_w(DEPTH)-1:0]    occ
);

    localparam int OW = occ_w(DEPTH);

    logic         w_vld  [DEPTH+1];
    logic         w_rdy  [DEPTH+1];
    logic [W-1:0] w_data [DEPTH+1];
    logic         w_in_xfer;
    logic         w_out_xfer;
    logic [OW-1:0] r_occ;

    assign w_vld[0]     = s_vld;
    assign w_data[0]    = s_data;
    assign w_rdy[DEPTH] = m_rdy;
    assign s_rdy        = w_rdy[0] & ~flush;
    assign m_vld        = w_vld[DEPTH] & ~flush;
    assign m_data       = w_data[DEPTH];
    assign occ          = r_occ;

    generate
        for (genvar g = 0; g < DEPTH; g++) begin : g_stage
            vr_stage #(
                .W    (W),
                .MODE (MODE)
            ) u_stage (
                .clk      (clk),
                .rst      (rst),
                .flush    (flush),
                .in_vld   (w_vld[g]),
                .in_data  (w_data[g]),
                .in_rdy   (w_rdy[g]),
                .out_vld  (w_vld[g+1]),
                .out_data (w_data[g+1]),
                .out_rdy  (w_rdy[g+1])
            );
        end
    endgenerate

    assign w_in_xfer  = s_vld & s_rdy;
    assign w_out_xfer = m_vld & m_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_occ <= '0;
        end else if (flush) begin
            r_occ <= '0;
        end else if (w_in_xfer && !w_out_xfer) begin
            r_occ <= r_occ + OW'(1);
        end else if (w_out_xfer && !w_in_xfer) begin
            r_occ <= r_occ - OW'(1);
        end
    end

endmodule
